// File: rtl/clock_controller_core.sv
// -----------------------------------------------------------------------------
// clock_controller_core
//
// Purpose:
//   Digital clock controller with three modes: free-running time display,
//   digit-by-digit time editing and (optionally) alarm editing.
//   Time and alarm are kept as packed BCD words:
//     {Ht[1:0], Ho[3:0], Mt[2:0], Mo[3:0], St[2:0], So[3:0]}
//   A prescaler divides clk down to a one-second tick while displaying time.
//
// Optional feature:
//   CLOCK_CTRL_ALARM_EN - when defined, the alarm register, alarm enable,
//   SET_ALARM mode and the ringing logic are built. When undefined,
//   set_alarm and toggle_alarm are ignored and o_clock_do_ring is tied to 0.
//
// Parameters:
//   CLOCK_FREQUENCY - i_clk cycles per one-second tick (minimum 2)
//
// Ports:
//   i_clk           in   rising-edge system clock
//   i_rst           in   synchronous active-high reset
//   i_clock_control in   [7] display_time [6] set_time [5] set_alarm [4] up
//                        [3] down [2] left [1] right [0] toggle_alarm
//   o_clock_sel     out  one-hot edit digit select (bit0 = So, bit5 = Ht)
//   o_clock_val     out  BCD value shown (time, or alarm in SET_ALARM)
//   o_clock_do_ring out  alarm ringing
//   o_clock_wr_en   out  one-cycle display refresh strobe
// -----------------------------------------------------------------------------
module clock_controller_core #(
   parameter int CLOCK_FREQUENCY = 27000000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [7:0]  i_clock_control,
   output logic [5:0]  o_clock_sel,
   output logic [19:0] o_clock_val,
   output logic        o_clock_do_ring,
   output logic        o_clock_wr_en
);

   localparam int PRE_W = (CLOCK_FREQUENCY > 2) ? $clog2(CLOCK_FREQUENCY) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLOCK_FREQUENCY - 1);

   typedef enum logic [1:0] {
      DISPLAY_TIME = 2'd0,
      SET_TIME     = 2'd1,
      SET_ALARM    = 2'd2
   } state_t;

   // Command decode
   logic do_display;
   logic do_set_time;
   logic do_set_alarm;
   logic do_up;
   logic do_down;
   logic do_left;
   logic do_right;

   assign do_display  = i_clock_control[7];
   assign do_set_time = i_clock_control[6];
   assign do_up       = i_clock_control[4];
   assign do_down     = i_clock_control[3];
   assign do_left     = i_clock_control[2];
   assign do_right    = i_clock_control[1];

`ifdef CLOCK_CTRL_ALARM_EN
   logic do_toggle;
   assign do_set_alarm = i_clock_control[5];
   assign do_toggle    = i_clock_control[0];
`else
   // Alarm commands have no function in this build.
   logic unused_alarm_cmds;
   assign do_set_alarm      = 1'b0;
   assign unused_alarm_cmds = i_clock_control[5] ^ i_clock_control[0];
`endif

   state_t            state_reg, state_next;
   logic [PRE_W-1:0]  pre_reg, pre_next;
   logic [19:0]       time_reg, time_next;
   logic [5:0]        sel_reg, sel_next;
   logic [19:0]       val_reg, val_next;
   logic [19:0]       val_prev_reg;
   logic [5:0]        sel_prev_reg;
   logic              init_reg;
   logic              wr_en_reg, wr_en_next;
   logic              tick;

`ifdef CLOCK_CTRL_ALARM_EN
   logic [19:0]       alarm_reg, alarm_next;
   logic              alarm_en_reg, alarm_en_next;
   logic              ring_reg, ring_next;
   logic [5:0]        ring_cnt_reg, ring_cnt_next;
`endif

   // Advance a BCD time word by one second, 23:59:59 wraps to 00:00:00.
   function automatic logic [19:0] next_second(input logic [19:0] v);
      logic [19:0] r;
      r = v;
      if (v[3:0] != 4'd9) begin
         r[3:0] = v[3:0] + 4'd1;
      end else begin
         r[3:0] = 4'd0;
         if (v[6:4] != 3'd5) begin
            r[6:4] = v[6:4] + 3'd1;
         end else begin
            r[6:4] = 3'd0;
            if (v[10:7] != 4'd9) begin
               r[10:7] = v[10:7] + 4'd1;
            end else begin
               r[10:7] = 4'd0;
               if (v[13:11] != 3'd5) begin
                  r[13:11] = v[13:11] + 3'd1;
               end else begin
                  r[13:11] = 3'd0;
                  if (v[19:18] == 2'd2 && v[17:14] == 4'd3) begin
                     r[19:14] = 6'd0;
                  end else if (v[17:14] == 4'd9) begin
                     r[17:14] = 4'd0;
                     r[19:18] = v[19:18] + 2'd1;
                  end else begin
                     r[17:14] = v[17:14] + 4'd1;
                  end
               end
            end
         end
      end
      return r;
   endfunction

   // Increment or decrement the selected digit inside its own range (no
   // carry). Ho is clamped to 3 whenever the result has Ht = 2.
   function automatic logic [19:0] edit_digit(input logic [19:0] v,
                                              input logic [5:0]  sel,
                                              input logic        up);
      logic [19:0] r;
      logic [3:0]  d;
      logic [3:0]  maxv;
      r    = v;
      d    = 4'd0;
      maxv = 4'd9;
      case (sel)
         6'b000001: begin d = v[3:0];            maxv = 4'd9; end
         6'b000010: begin d = {1'b0, v[6:4]};    maxv = 4'd5; end
         6'b000100: begin d = v[10:7];           maxv = 4'd9; end
         6'b001000: begin d = {1'b0, v[13:11]};  maxv = 4'd5; end
         6'b010000: begin
            d    = v[17:14];
            maxv = (v[19:18] == 2'd2) ? 4'd3 : 4'd9;
         end
         6'b100000: begin d = {2'b00, v[19:18]}; maxv = 4'd2; end
         default: ;
      endcase
      if (up) begin
         d = (d >= maxv) ? 4'd0 : d + 4'd1;
      end else begin
         d = (d == 4'd0) ? maxv : d - 4'd1;
      end
      case (sel)
         6'b000001: r[3:0]   = d;
         6'b000010: r[6:4]   = d[2:0];
         6'b000100: r[10:7]  = d;
         6'b001000: r[13:11] = d[2:0];
         6'b010000: r[17:14] = d;
         6'b100000: r[19:18] = d[1:0];
         default: ;
      endcase
      if (r[19:18] == 2'd2 && r[17:14] > 4'd3) begin
         r[17:14] = 4'd3;
      end
      return r;
   endfunction

   always_comb begin
      state_next = state_reg;
      pre_next   = pre_reg;
      time_next  = time_reg;
      sel_next   = sel_reg;
      tick       = 1'b0;
`ifdef CLOCK_CTRL_ALARM_EN
      alarm_next    = alarm_reg;
      alarm_en_next = alarm_en_reg;
      ring_next     = ring_reg;
      ring_cnt_next = ring_cnt_reg;
`endif

      // Mode selection, display_time > set_time > set_alarm
      if (do_display) begin
         state_next = DISPLAY_TIME;
      end else if (do_set_time) begin
         state_next = SET_TIME;
      end else if (do_set_alarm) begin
         state_next = SET_ALARM;
      end

      // Prescaler only runs while displaying; entering display restarts it.
      if (do_display) begin
         pre_next = '0;
      end else if (state_reg == DISPLAY_TIME) begin
         if (pre_reg == PRE_MAX) begin
            pre_next = '0;
            tick     = 1'b1;
         end else begin
            pre_next = pre_reg + 1'b1;
         end
      end

      if (tick) begin
         time_next = next_second(time_reg);
      end

      // Digit select and edits; a mode command in the same cycle wins.
      if (do_display) begin
         sel_next = 6'b000000;
      end else if (do_set_time || do_set_alarm) begin
         sel_next = 6'b000001;
      end else if (state_reg != DISPLAY_TIME) begin
         if (do_up || do_down) begin
`ifdef CLOCK_CTRL_ALARM_EN
            if (state_reg == SET_ALARM) begin
               alarm_next = edit_digit(alarm_reg, sel_reg, do_up);
            end else begin
               time_next = edit_digit(time_reg, sel_reg, do_up);
            end
`else
            time_next = edit_digit(time_reg, sel_reg, do_up);
`endif
         end else if (do_left) begin
            sel_next = {sel_reg[4:0], sel_reg[5]};
         end else if (do_right) begin
            sel_next = {sel_reg[0], sel_reg[5:1]};
         end
      end

`ifdef CLOCK_CTRL_ALARM_EN
      // Toggle while ringing silences and disarms; otherwise it flips the
      // enable. Ringing self-clears after 60 further ticks.
      if (do_toggle) begin
         if (ring_reg) begin
            ring_next     = 1'b0;
            alarm_en_next = 1'b0;
         end else begin
            alarm_en_next = ~alarm_en_reg;
         end
      end else if (ring_reg) begin
         if (tick) begin
            if (ring_cnt_reg == 6'd59) begin
               ring_next = 1'b0;
            end else begin
               ring_cnt_next = ring_cnt_reg + 6'd1;
            end
         end
      end else if (alarm_en_reg && tick && (time_next == alarm_reg)) begin
         ring_next     = 1'b1;
         ring_cnt_next = 6'd0;
      end

      val_next = (state_next == SET_ALARM) ? alarm_next : time_next;
`else
      val_next = time_next;
`endif

      // Strobe one cycle after a visible change, and once after reset.
      wr_en_next = init_reg || (val_reg != val_prev_reg) || (sel_reg != sel_prev_reg);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_reg    <= DISPLAY_TIME;
         pre_reg      <= '0;
         time_reg     <= 20'd0;
         sel_reg      <= 6'd0;
         val_reg      <= 20'd0;
         val_prev_reg <= 20'd0;
         sel_prev_reg <= 6'd0;
         init_reg     <= 1'b1;
         wr_en_reg    <= 1'b0;
`ifdef CLOCK_CTRL_ALARM_EN
         alarm_reg    <= 20'd0;
         alarm_en_reg <= 1'b0;
         ring_reg     <= 1'b0;
         ring_cnt_reg <= 6'd0;
`endif
      end else begin
         state_reg    <= state_next;
         pre_reg      <= pre_next;
         time_reg     <= time_next;
         sel_reg      <= sel_next;
         val_reg      <= val_next;
         val_prev_reg <= val_reg;
         sel_prev_reg <= sel_reg;
         init_reg     <= 1'b0;
         wr_en_reg    <= wr_en_next;
`ifdef CLOCK_CTRL_ALARM_EN
         alarm_reg    <= alarm_next;
         alarm_en_reg <= alarm_en_next;
         ring_reg     <= ring_next;
         ring_cnt_reg <= ring_cnt_next;
`endif
      end
   end

   assign o_clock_sel   = sel_reg;
   assign o_clock_val   = val_reg;
   assign o_clock_wr_en = wr_en_reg;
`ifdef CLOCK_CTRL_ALARM_EN
   assign o_clock_do_ring = ring_reg;
`else
   assign o_clock_do_ring = 1'b0;
`endif

endmodule

// File: tb/tb_clock_controller_core.sv
// -----------------------------------------------------------------------------
// tb_clock_controller_core
//
// Directed bench for clock_controller_core with CLOCK_FREQUENCY = 2.
// Inputs change on the falling edge; outputs are checked on the falling edge
// after the rising edge that consumed the command.
// -----------------------------------------------------------------------------
module tb_clock_controller_core;

   localparam logic [7:0] C_NONE  = 8'h00;
   localparam logic [7:0] C_DISP  = 8'h80;
   localparam logic [7:0] C_SETT  = 8'h40;
   localparam logic [7:0] C_SETA  = 8'h20;
   localparam logic [7:0] C_UP    = 8'h10;
   localparam logic [7:0] C_DOWN  = 8'h08;
   localparam logic [7:0] C_LEFT  = 8'h04;
   localparam logic [7:0] C_RIGHT = 8'h02;
   localparam logic [7:0] C_TOG   = 8'h01;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  ctrl;
   logic [5:0]  sel;
   logic [19:0] val;
   logic        ring;
   logic        wr_en;

   int n_compared   = 0;
   int n_mismatched = 0;

   clock_controller_core #(.CLOCK_FREQUENCY(2)) dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_clock_control (ctrl),
      .o_clock_sel     (sel),
      .o_clock_val     (val),
      .o_clock_do_ring (ring),
      .o_clock_wr_en   (wr_en)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp);
      n_compared++;
      assert (obs === exp) else begin
         n_mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
      $display("check %-16s observed %h expected %h", tag, obs, exp);
   endtask

   task automatic step(input logic [7:0] cmd);
      ctrl = cmd;
      @(negedge clk);
      ctrl = C_NONE;
   endtask

   task automatic steps(input logic [7:0] cmd, input int n);
      for (int k = 0; k < n; k++) step(cmd);
   endtask

   task automatic do_reset();
      rst  = 1'b1;
      ctrl = C_NONE;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst  = 1'b1;
      ctrl = C_NONE;

      // Reset for two cycles
      @(negedge clk);
      @(negedge clk);
      check("rst_val",   val,          20'h00000);
      check("rst_sel",   20'(sel),     20'h00000);
      check("rst_ring",  20'(ring),    20'h00000);
      check("rst_wr_en", 20'(wr_en),   20'h00000);
      rst = 1'b0;

      // Free-running display, one second every two cycles
      step(C_NONE);
      check("wr_after_rel", 20'(wr_en), 20'h00001);
      check("disp_val_c1",  val,        20'h00000);
      step(C_NONE);
      check("wr_once",      20'(wr_en), 20'h00000);
      check("disp_val_c2",  val,        20'h00001);
      step(C_NONE);
      check("wr_on_change", 20'(wr_en), 20'h00001);
      steps(C_NONE, 3);
      check("disp_val_c6",  val,        20'h00003);
      check("disp_sel",     20'(sel),   20'h00000);

      // Time editing from 00:00:00
      do_reset();
      step(C_SETT);
      check("sett_sel",  20'(sel), 20'h00001);
      check("sett_val",  val,      20'h00000);
      steps(C_UP, 3);
      step(C_LEFT);
      check("left_sel",  20'(sel), 20'h00002);
      step(C_UP);
      check("edit_val",  val,      20'h00013);
      steps(C_NONE, 3);
      check("no_count",  val,      20'h00013);
      step(C_SETT | C_UP);
      check("mode_blk_val", val,      20'h00013);
      check("mode_blk_sel", 20'(sel), 20'h00001);

      // Preload 23:59:59 through edits
      step(C_LEFT);
      step(C_UP | C_DOWN);
      check("up_over_down", val, 20'h00023);
      steps(C_DOWN, 3);
      check("st_wrap_down", val, 20'h00053);
      step(C_RIGHT);
      steps(C_DOWN, 4);
      check("so_wrap_down", val, 20'h00059);
      steps(C_LEFT, 2);
      step(C_DOWN);
      step(C_LEFT);
      step(C_DOWN);
      step(C_LEFT);
      step(C_DOWN);
      check("ho_nine",   val, 20'h26CD9);
      step(C_LEFT);
      step(C_DOWN);
      check("ht_clamp",  val,      20'h8ECD9);
      check("ht_sel",    20'(sel), 20'h00020);
      step(C_DISP);
      check("disp_entry_sel", 20'(sel), 20'h00000);
      check("disp_entry_val", val,      20'h8ECD9);
      steps(C_NONE, 2);
      check("midnight",  val, 20'h00000);

      // Hours tens up with clamp, wrap of Ht and select rotation
      step(C_SETT);
      steps(C_LEFT, 4);
      check("sel_ho",    20'(sel), 20'h00010);
      step(C_DOWN);
      step(C_LEFT);
      step(C_UP);
      check("h19",       val, 20'h64000);
      step(C_UP);
      check("h23_clamp", val, 20'h8C000);
      step(C_UP);
      check("ht_wrap",   val, 20'h0C000);
      step(C_LEFT);
      check("left_wrap",  20'(sel), 20'h00001);
      step(C_RIGHT);
      check("right_wrap", 20'(sel), 20'h00020);

      // Reset asserted together with an edit
      rst  = 1'b1;
      ctrl = C_UP;
      @(negedge clk);
      ctrl = C_NONE;
      check("rst_edit_val", val,      20'h00000);
      check("rst_edit_sel", 20'(sel), 20'h00000);
      @(negedge clk);
      rst = 1'b0;

`ifdef CLOCK_CTRL_ALARM_EN
      // Alarm at 00:00:02
      step(C_SETA);
      check("seta_sel",  20'(sel), 20'h00001);
      steps(C_UP, 2);
      check("alarm_val", val, 20'h00002);
      step(C_TOG);
      step(C_DISP);
      check("show_time", val, 20'h00000);
      steps(C_NONE, 2);
      check("no_ring_1s", 20'(ring), 20'h00000);
      steps(C_NONE, 2);
      check("ring_val",  val,        20'h00002);
      check("ring_on",   20'(ring),  20'h00001);
      step(C_TOG);
      check("ring_off",  20'(ring),  20'h00000);
`else
      // Alarm commands have no effect in this build
      step(C_SETT);
      step(C_SETA | C_UP);
      check("seta_ignored", val,      20'h00001);
      check("seta_sel",     20'(sel), 20'h00001);
      step(C_TOG);
      steps(C_NONE, 2);
      check("still_set",    val,       20'h00001);
      check("ring_const",   20'(ring), 20'h00000);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/clock_controller_core.md
CLOCK_CONTROLLER_CORE -- requirements
Module: clock_controller

Interface
REQ-001 SHALL have parameter CLOCK_FREQUENCY, default 27000000, meaning i_clk cycles per one-second tick (minimum 2).
REQ-002 SHALL have one clock and one reset: reset is synchronous and active-high; ports are i_clk and i_rst.
REQ-003 SHALL have port i_clk, input, 1 bit: rising-edge system clock.
REQ-004 SHALL have port i_rst, input, 1 bit: synchronous active-high reset.
REQ-005 SHALL have port i_clock_control, input, 8 bits: packed clock_op_t, sampled every cycle, with bits 7..0 as follows.
- [7] clock_do_display_time
- [6] clock_do_set_time
- [5] clock_do_set_alarm
- [4] clock_do_up
- [3] clock_do_down
- [2] clock_do_left
- [1] clock_do_right
- [0] clock_do_toggle_alarm
REQ-006 SHALL have port o_clock_sel, output, 6 bits: one-hot edit-digit select; bit0 = seconds ones, bit5 = hours tens; 0 = no edit.
REQ-007 SHALL have port o_clock_val, output, 20 bits: shown BCD value {Ht[1:0],Ho[3:0],Mt[2:0],Mo[3:0],St[2:0],So[3:0]}, MSB first.
REQ-008 SHALL have port o_clock_do_ring, output, 1 bit: alarm ringing.
REQ-009 SHALL have port o_clock_wr_en, output, 1 bit: display refresh strobe.

Function
REQ-010 SHALL use three states, DISPLAY_TIME, SET_TIME and SET_ALARM; mode commands move to the named state from any state on the next edge.
REQ-011 SHALL resolve simultaneous mode commands with priority display_time > set_time > set_alarm; a mode command SHALL block edits in that cycle.
REQ-012 SHALL count a prescaler 0..CLOCK_FREQUENCY-1 in DISPLAY_TIME only; at CLOCK_FREQUENCY-1 it SHALL wrap to 0 and advance time by one second.
REQ-013 SHALL clear the prescaler on entry to DISPLAY_TIME.
REQ-014 SHALL roll time over in BCD: So 9->0 carries to St; St 5->0 carries to Mo; Mo 9->0 carries to Mt; Mt 5->0 carries to hours; 23:59:59 -> 00:00:00.
REQ-015 SHALL set o_clock_sel to 000000 in DISPLAY_TIME and to 000001 on each entry to SET_TIME or SET_ALARM.
REQ-016 SHALL, in SET_TIME/SET_ALARM only, apply one edit per cycle to the time/alarm register, with priority up > down > left > right.
REQ-017 SHALL make up/down increment/decrement only the selected digit, wrapping within its own range with no carry.
- So, Mo: 0-9
- St, Mt: 0-5
- Ht: 0-2
- Ho: 0-9, or 0-3 when Ht = 2
REQ-018 SHALL clamp Ho to 3 in the same cycle whenever Ht becomes 2 with Ho > 3.
REQ-019 SHALL make left rotate o_clock_sel toward the MSB (bit5 -> bit0) and right rotate it toward the LSB (bit0 -> bit5).
REQ-020 SHALL drive o_clock_val with the time register in DISPLAY_TIME and SET_TIME, and with the alarm register in SET_ALARM.
REQ-021 SHALL make toggle_alarm flip alarm_en in any state; if ringing, toggle_alarm SHALL clear ring and alarm_en SHALL become 0.
REQ-022 SHALL set ring when alarm_en = 1 and the time register changes on a tick to a value equal to the alarm register; ring SHALL stay set until toggle_alarm, or until 60 further ticks pass.
REQ-023 SHALL pulse o_clock_wr_en high for exactly one cycle on the cycle after o_clock_val or o_clock_sel changes, and on the first cycle after reset release.
REQ-024 SHALL drive all outputs from registers; a command sampled at edge N SHALL be visible at edge N+1.

Reset
REQ-025 SHALL, while i_rst = 1 at a rising edge, load the following, with reset taking priority over every command and tick.
- state = DISPLAY_TIME
- time = 00:00:00
- alarm = 00:00:00
- alarm_en = 0, ring = 0
- prescaler = 0
- o_clock_sel = 000000, o_clock_val = 0, o_clock_do_ring = 0, o_clock_wr_en = 0
REQ-026 SHALL, when reset is asserted mid-edit, discard the edit and leave no partial state.

Configuration
REQ-027 SHALL include the alarm function only when CLOCK_CTRL_ALARM_EN is defined.
- Without the macro: set_alarm and toggle_alarm are ignored, and o_clock_do_ring is constant 0.
- With the macro: full alarm behaviour per REQ-020..022.

Verification
REQ-028 SHALL cover these directed scenarios with CLOCK_FREQUENCY = 2.
- Reset 2 cycles -> outputs all 0, wr_en pulses once after release.
- DISPLAY_TIME, 6 cycles -> o_clock_val = 00:00:03 (20'h00003).
- set_time, up x3, left, up -> sel 000010, val 00:00:13, no counting.
- Time 23:59:59 (preloaded via edits), display_time, 2 cycles -> 00:00:00.
- Ht = 1, Ho = 9, up on Ht -> Ht = 2, Ho = 3; up on Ht again -> Ht = 0.
- Alarm 00:00:02 with toggle -> alarm_en = 1; display_time -> ring at 00:00:02; toggle -> ring 0.
